// File: rtl/fifo_stream_out.sv
// fifo_stream_out: drains a sync_fifo (one-cycle read latency) into a valid/ready stream
// through a 2-entry in-order output buffer. Define STREAM_LAST_EN to generate m_last framing.
module fifo_stream_out #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [1:0]            occupancy
);

    logic                  inflight;
    logic                  rst_done;
    logic                  pop;
    logic                  capture;
    logic [2:0]            committed;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;

    assign m_valid = (occupancy != 2'd0);
    assign pop     = m_valid && m_ready;
    assign capture = inflight;
    assign m_data  = head_q;

    // Slots already promised: held words plus the one arriving next cycle, minus the one leaving now.
    always_comb begin
        committed  = {1'b0, occupancy} + {2'b0, inflight} - {2'b0, pop};
        fifo_rd_en = rst_done && !fifo_empty && (committed < 3'd2);
    end

    // rst_done keeps the read strobe low for the first cycle after reset release.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done <= 1'b0;
            inflight <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            inflight <= fifo_rd_en;
        end
    end

    // NOTE: the two data slots are reset on purpose so m_data reads zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            occupancy <= 2'd0;
        end else begin
            case ({capture, pop})
                2'b10: begin
                    if (occupancy == 2'd0) begin
                        head_q <= fifo_data;
                    end else begin
                        tail_q <= fifo_data;
                    end
                    occupancy <= occupancy + 2'd1;
                end
                2'b01: begin
                    head_q    <= tail_q;
                    occupancy <= occupancy - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever remains.
                    if (occupancy == 2'd1) begin
                        head_q <= fifo_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef STREAM_LAST_EN
    logic [7:0] beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= 8'd0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == 8'(PKT_LEN - 1)) ? 8'd0 : beat_cnt + 8'd1;
        end
    end

    assign m_last = m_valid && (beat_cnt == 8'(PKT_LEN - 1));
`else
    assign m_last = 1'b0;
`endif

    a_pkt_len_range: assert property (@(posedge clk) (PKT_LEN >= 2) && (PKT_LEN <= 256));
    a_no_overflow:   assert property (@(posedge clk) disable iff (!rst_n)
                                      ({1'b0, occupancy} + {2'b0, inflight}) <= 3'd2);
    a_no_rd_empty:   assert property (@(posedge clk) disable iff (!rst_n)
                                      !(fifo_rd_en && fifo_empty));

endmodule

// File: tb/tb_fifo_stream_out.sv
// tb_fifo_stream_out: directed bench for fifo_stream_out with a behavioural sync_fifo upstream.
// Expected m_last follows STREAM_LAST_EN the same way the design does.
module tb_fifo_stream_out;

    localparam int DW  = 8;
    localparam int PKT = 4;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [1:0]    occupancy;

    fifo_stream_out #(.DATA_WIDTH(DW), .PKT_LEN(PKT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    // Upstream sync_fifo: data_out updates on the edge that accepts a read.
    logic [DW-1:0] fmem [256];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= fmem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int first_rd = -1;
    int viol    = 0;

    logic [DW-1:0] got_data [$];
    logic          got_last [$];
    int            got_cyc  [$];

    typedef struct {
        logic          rdy;
        logic          rd_en;
        logic          valid;
        logic [1:0]    occ;
        logic [DW-1:0] data;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        fmem[wr_ptr[7:0]] = v;
        wr_ptr++;
    endtask

    // Drive at the falling edge, sample 1 ns later; a beat seen here transfers on the next rising edge.
    task automatic step(input logic rdy);
        @(negedge clk);
        m_ready = rdy;
        #1;
        cyc++;
        if (fifo_rd_en && fifo_empty) viol++;
        if (fifo_rd_en && first_rd < 0) first_rd = cyc;
        if (m_valid && m_ready) begin
            got_data.push_back(m_data);
            got_last.push_back(m_last);
            got_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_log();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        first_rd = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, fifo_rd_en, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_data"},  m_data, 0);
        check({tag, "_last"},  m_last, 0);
        check({tag, "_occ"},   occupancy, 0);
    endtask

    task automatic reset_and_release();
        @(negedge clk);
        rst_n   = 1'b0;
        m_ready = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_rd_en", fifo_rd_en, 0);
    endtask

    task automatic drain(input int n, input bit toggle, input int budget);
        int   k;
        logic r;
        k = 0;
        r = 1'b1;
        while (got_data.size() < n && k < budget) begin
            step(r);
            if (toggle) r = ~r;
            k++;
        end
        check("drain_count", got_data.size(), n);
    endtask

    function automatic logic exp_last(input int beat);
`ifdef STREAM_LAST_EN
        return (beat % PKT) == (PKT - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_log(input string tag, input int first, input int stride, input int n, input int beat0);
        for (int i = 0; i < n; i++) begin
            if (i < got_data.size()) begin
                check($sformatf("%s%0d_data", tag, i), got_data[i], first + i * stride);
                check($sformatf("%s%0d_last", tag, i), got_last[i], exp_last(beat0 + i));
            end
        end
    endtask

    initial begin
        // Cycle-by-cycle view after release with three words waiting upstream.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 2'd1, 8'h11};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h11};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 2'd2, 8'h11};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h22};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 2'd1, 8'h33};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h33};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00};

        push(8'h11);
        push(8'h22);
        push(8'h33);
        reset_and_release();
        clear_log();
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].rdy);
            check($sformatf("vec%0d_rd_en", i), fifo_rd_en, tbl[i].rd_en);
            check($sformatf("vec%0d_valid", i), m_valid, tbl[i].valid);
            check($sformatf("vec%0d_occ", i), occupancy, tbl[i].occ);
            if (tbl[i].valid) check($sformatf("vec%0d_data", i), m_data, tbl[i].data);
        end
        check("vec_xfers", got_data.size(), 3);
        check_log("vec", 8'h11, 8'h11, 3, 0);

        // Back-to-back drain of 1..20 at full rate.
        reset_and_release();
        clear_log();
        for (int i = 1; i <= 20; i++) push(DW'(i));
        drain(20, 1'b0, 80);
        check_log("seq", 1, 1, 20, 0);
        if (got_data.size() == 20) begin
            check("seq_first_latency", got_cyc[0] - first_rd, 2);
            check("seq_back_to_back", got_cyc[19] - got_cyc[0], 19);
        end

        // Downstream stall with eight words queued.
        clear_log();
        for (int i = 0; i < 8; i++) push(DW'(8'h40 + i));
        for (int i = 0; i < 10; i++) step(1'b0);
        check("stall_occ", occupancy, 2);
        check("stall_rd_en", fifo_rd_en, 0);
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, 8'h40);
        check("stall_no_xfer", got_data.size(), 0);
        drain(8, 1'b0, 40);
        check_log("stall", 8'h40, 1, 8, 0);

        // m_ready alternating every cycle.
        clear_log();
        for (int i = 0; i < 16; i++) push(DW'(8'h80 + i));
        drain(16, 1'b1, 80);
        check_log("toggle", 8'h80, 1, 16, 0);
        for (int i = 0; i < 4; i++) step(1'b1);
        check("toggle_no_dup", got_data.size(), 16);

        // Reset while the buffer is full; the beat counter is left mid-packet beforehand.
        clear_log();
        push(8'hB0);
        drain(1, 1'b0, 20);
        check_log("pre", 8'hB0, 1, 1, 0);
        clear_log();
        for (int i = 0; i < 6; i++) push(DW'(8'hC0 + i));
        for (int i = 0; i < 6; i++) step(1'b0);
        check("full_occ", occupancy, 2);
        check("full_data", m_data, 8'hC0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("async_release_rd_en", fifo_rd_en, 0);
        clear_log();
        drain(4, 1'b0, 30);
        check_log("post_rst", 8'hC2, 1, 4, 0);

        check("rd_en_while_empty", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
